// File: rtl/pattern_pkg.sv
// Shared types and default widths for the serial pattern generator.
package pattern_pkg;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_SEND = 3'b001,
    ST_GAP  = 3'b010,
    ST_DONE = 3'b011
  } state_e;

endpackage

// File: rtl/pattern_bit_ctr.sv
// Loadable down-counter holding the index of the pattern bit currently on the line.
module pattern_bit_ctr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern generator: sends pat[len_m1:0] MSB-first reps times with idle gaps.
module pattern_gen
  import pattern_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [PAT_W-1:0]         pat,
  input  logic [$clog2(PAT_W)-1:0] len_m1,
  input  logic [CNT_W-1:0]         reps,
  input  logic [CNT_W-1:0]         gap,
  output logic                     out1,
  output logic                     vld,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W = $clog2(PAT_W);

  state_e             state_q,     state_d;
  logic [PAT_W-1:0]   pat_q,       pat_d;
  logic [IDX_W-1:0]   len_q,       len_d;
  logic [CNT_W-1:0]   gap_len_q,   gap_len_d;
  logic [CNT_W-1:0]   reps_left_q, reps_left_d;
  logic [CNT_W-1:0]   gap_cnt_q,   gap_cnt_d;
  logic               out1_q,      out1_d;
  logic               vld_q,       vld_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  logic               ctr_load;
  logic               ctr_dec;
  logic [IDX_W-1:0]   ctr_val;
  logic [IDX_W-1:0]   ctr_idx;
  logic               ctr_tc_c;

  pattern_bit_ctr #(.W(IDX_W)) u_bit_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_val),
    .dec      (ctr_dec),
    .cnt      (ctr_idx),
    .tc_c     (ctr_tc_c)
  );

  // Outputs are computed for the next state so the registered values line up with state_q.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    gap_len_d   = gap_len_q;
    reps_left_d = reps_left_q;
    gap_cnt_d   = gap_cnt_q;
    out1_d      = 1'b0;
    vld_d       = 1'b0;
    done_d      = 1'b0;
    ctr_load    = 1'b0;
    ctr_dec     = 1'b0;
    ctr_val     = len_q;

    case (state_q)
      ST_IDLE: begin
        if (start && (reps != '0)) begin
          pat_d       = pat;
          len_d       = len_m1;
          gap_len_d   = gap;
          reps_left_d = reps;
          ctr_load    = 1'b1;
          ctr_val     = len_m1;
          out1_d      = pat[len_m1];
          vld_d       = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!ctr_tc_c) begin
          ctr_dec = 1'b1;
          out1_d  = pat_q[ctr_idx - IDX_W'(1)];
          vld_d   = 1'b1;
        end else if (reps_left_q == CNT_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          reps_left_d = reps_left_q - CNT_W'(1);
          if (gap_len_q == '0) begin
            ctr_load = 1'b1;
            out1_d   = pat_q[len_q];
            vld_d    = 1'b1;
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == CNT_W'(1)) begin
          ctr_load = 1'b1;
          out1_d   = pat_q[len_q];
          vld_d    = 1'b1;
          state_d  = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      gap_len_q   <= '0;
      reps_left_q <= '0;
      gap_cnt_q   <= '0;
      out1_q      <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      gap_len_q   <= gap_len_d;
      reps_left_q <= reps_left_d;
      gap_cnt_q   <= gap_cnt_d;
      out1_q      <= out1_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out1 = out1_q;
  assign vld  = vld_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Randomized self-checking bench for pattern_gen against a cycle-list reference model.
module tb_pattern_gen;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pat;
  logic [2:0] len_m1;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       out1;
  logic       vld;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pat    (pat),
    .len_m1 (len_m1),
    .reps   (reps),
    .gap    (gap),
    .out1   (out1),
    .vld    (vld),
    .busy   (busy),
    .done   (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected {out1,vld,busy,done} for every cycle after the start edge, built from the
  // transmission rules: bits MSB-first per repetition, gap idles between, one done cycle.
  task automatic run_case(input logic [7:0] p, input int len, input int rp, input int gp,
                          input int rst_cyc, input int restart_cyc, input bit rst_on_start,
                          input string name);
    logic [3:0] exp_q[$];
    logic [7:0] pv;
    int         ndone;
    int         exp_done;
    int         tail;
    ndone    = 0;
    exp_done = 0;
    pv       = p;
    if (!rst_on_start && rp > 0) begin
      for (int r = 0; r < rp; r++) begin
        for (int b = len; b >= 0; b--) exp_q.push_back({pv[b], 1'b1, 1'b1, 1'b0});
        if (r < rp - 1)
          for (int g = 0; g < gp; g++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0011);
    end
    tail = (rp == 0 || rst_on_start) ? 10 : 3;
    for (int i = 0; i < tail; i++) exp_q.push_back(4'b0000);
    if (rst_cyc > 0)
      for (int i = rst_cyc; i < exp_q.size(); i++) exp_q[i] = 4'b0000;
    foreach (exp_q[i]) exp_done += int'(exp_q[i][0]);

    @(negedge clk);
    pat    = p;
    len_m1 = 3'(len);
    reps   = 4'(rp);
    gap    = 4'(gp);
    start  = 1'b1;
    rst    = rst_on_start;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("%s c%0d out1", name, c), 32'(out1), 32'(exp_q[c-1][3]));
      check_val($sformatf("%s c%0d vld", name, c),  32'(vld),  32'(exp_q[c-1][2]));
      check_val($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(exp_q[c-1][1]));
      check_val($sformatf("%s c%0d done", name, c), 32'(done), 32'(exp_q[c-1][0]));
      ndone += int'(done);
      @(negedge clk);
      start = (c == restart_cyc);
      rst   = (c == rst_cyc);
      if (start) begin
        pat    = ~p;
        len_m1 = 3'($urandom);
        reps   = 4'($urandom_range(1, 15));
        gap    = 4'($urandom);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
    check_val($sformatf("%s done_count", name), 32'(ndone), 32'(exp_done));
  endtask

  initial begin
    int len, rp, gp, total, rc, sc;
    rst    = 1'b1;
    start  = 1'b1;
    pat    = 8'hff;
    len_m1 = 3'd7;
    reps   = 4'd3;
    gap    = 4'd1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset out1", 32'(out1), 32'd0);
    check_val("reset vld",  32'(vld),  32'd0);
    check_val("reset busy", 32'(busy), 32'd0);
    check_val("reset done", 32'(done), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    run_case(8'b00011010, 4, 1, 0, 0, 0, 1'b0, "single");
    run_case(8'b00000101, 2, 3, 2, 0, 0, 1'b0, "gapped");
    run_case(8'h5a, 3, 0, 5, 0, 0, 1'b0, "reps0");
    run_case(8'b00011010, 4, 2, 1, 0, 2, 1'b0, "restart");
    run_case(8'b00011010, 4, 1, 0, 3, 0, 1'b0, "rst_mid");
    run_case(8'h01, 0, 15, 0, 0, 0, 1'b0, "len1_rep15");
    run_case(8'hb7, 7, 15, 15, 0, 0, 1'b0, "max");
    run_case(8'h33, 3, 2, 1, 0, 0, 1'b1, "rst_start");

    for (int t = 0; t < 30; t++) begin
      len = int'($urandom_range(0, 7));
      rp  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      gp  = int'($urandom_range(0, 15));
      total = (rp > 0) ? (len + 1) * rp + gp * (rp - 1) : 0;
      rc = (rp > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, total + 1)) : 0;
      sc = (rp > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, total + 1)) : 0;
      run_case(8'($urandom), len, rp, gp, rc, sc, 1'b0, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
